// File: rtl/issue_sequencer.sv
// Decode-stage issue sequencer: fetch FIFO, resource-gated decode pulse
// generation and mispredict flush / fetch redirect handling.
module issue_sequencer #(
   parameter int QUEUE_DEPTH = 4,
   parameter int PTR_W       = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             fetchValid,
   input  logic [31:0]      fetchInstr,
   input  logic [31:0]      fetchPc,
   output logic             fetchReady,
   input  logic             robNotFull,
   input  logic             rsNotFull,
   input  logic             flush,
   input  logic [31:0]      flushPc,
   output logic             decodePulse,
   output logic [31:0]      decodeInstr,
   output logic [31:0]      decodePc,
   output logic             decodeAvailable,
   output logic             stall,
   output logic             fetchRedirect,
   output logic [31:0]      fetchRedirectPc,
   output logic [PTR_W:0]   queueCount
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] PULSE = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;

   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(QUEUE_DEPTH);

   logic [1:0]       state;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count;
   logic [31:0]      instrMem [QUEUE_DEPTH];
   logic [31:0]      pcMem    [QUEUE_DEPTH];
   logic             push;
   logic             issue;

   // Ready is taken from the pre-pop count, so a push never lands on a full FIFO.
   assign fetchReady = (count < DEPTH_CNT) && (state != FLUSH);
   assign push       = fetchValid && fetchReady && !flush;
   assign issue      = (state == IDLE) && !flush && (count != '0) && robNotFull && rsNotFull;
   assign queueCount = count;

   // Storage holds no control meaning, so it is left out of reset.
   always_ff @(posedge clock) begin
      if (push) begin
         instrMem[tail] <= fetchInstr;
         pcMem[tail]    <= fetchPc;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         head            <= '0;
         tail            <= '0;
         count           <= '0;
         decodePulse     <= 1'b0;
         decodeAvailable <= 1'b0;
         decodeInstr     <= '0;
         decodePc        <= '0;
         stall           <= 1'b0;
         fetchRedirect   <= 1'b0;
         fetchRedirectPc <= '0;
      end else if (flush) begin
         state           <= FLUSH;
         head            <= '0;
         tail            <= '0;
         count           <= '0;
         decodePulse     <= 1'b0;
         decodeAvailable <= 1'b0;
         stall           <= 1'b0;
         fetchRedirect   <= 1'b1;
         fetchRedirectPc <= flushPc;
      end else begin
         fetchRedirect <= 1'b0;
         if (push)  tail <= tail + 1'b1;
         if (issue) head <= head + 1'b1;
         case ({push, issue})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         case (state)
            IDLE: begin
               if (issue) begin
                  decodeInstr     <= instrMem[head];
                  decodePc        <= pcMem[head];
                  decodePulse     <= 1'b1;
                  decodeAvailable <= 1'b1;
                  stall           <= 1'b0;
                  state           <= PULSE;
               end else begin
                  stall <= (count != '0);
               end
            end
            // The decoder is edge-triggered, so the pulse always returns low before the next issue.
            PULSE: begin
               decodePulse     <= 1'b0;
               decodeAvailable <= 1'b0;
               stall           <= 1'b0;
               state           <= IDLE;
            end
            FLUSH: begin
               state <= IDLE;
            end
            default: begin
               decodePulse     <= 1'b0;
               decodeAvailable <= 1'b0;
               state           <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_issue_sequencer.sv
// Directed bench for issue_sequencer: issue timing, full FIFO, wrap, flush,
// resource stall and reset behaviour.
module tb_issue_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        fetchValid;
   logic [31:0] fetchInstr;
   logic [31:0] fetchPc;
   logic        fetchReady;
   logic        robNotFull;
   logic        rsNotFull;
   logic        flush;
   logic [31:0] flushPc;
   logic        decodePulse;
   logic [31:0] decodeInstr;
   logic [31:0] decodePc;
   logic        decodeAvailable;
   logic        stall;
   logic        fetchRedirect;
   logic [31:0] fetchRedirectPc;
   logic [2:0]  queueCount;

   int nPass  = 0;
   int nTotal = 0;

   issue_sequencer #(.QUEUE_DEPTH(4), .PTR_W(2)) dut (
      .clock(clock), .reset(reset),
      .fetchValid(fetchValid), .fetchInstr(fetchInstr), .fetchPc(fetchPc),
      .fetchReady(fetchReady), .robNotFull(robNotFull), .rsNotFull(rsNotFull),
      .flush(flush), .flushPc(flushPc),
      .decodePulse(decodePulse), .decodeInstr(decodeInstr), .decodePc(decodePc),
      .decodeAvailable(decodeAvailable), .stall(stall),
      .fetchRedirect(fetchRedirect), .fetchRedirectPc(fetchRedirectPc),
      .queueCount(queueCount)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTotal++;
      if (got === exp) nPass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   logic [31:0] expQ[$];
   logic [31:0] expInstr;
   int          mCnt;
   bit          mPulse;
   bit          mPush;
   bit          mIssue;
   int          nPushed;
   int          nPulses;

   initial begin
      reset = 1'b1; fetchValid = 1'b0; fetchInstr = '0; fetchPc = '0;
      robNotFull = 1'b1; rsNotFull = 1'b1; flush = 1'b0; flushPc = '0;
      step(); step();
      chk("rst_pulse", 32'(decodePulse), 0);
      chk("rst_count", 32'(queueCount), 0);
      chk("rst_ready", 32'(fetchReady), 1);
      chk("rst_redir_pc", fetchRedirectPc, 0);
      chk("rst_instr", decodeInstr, 0);
      reset = 1'b0;

      // Back-to-back issue
      fetchValid = 1'b1; fetchInstr = 32'h00500093; fetchPc = 32'h1000;
      step();
      chk("b2b_cnt1", 32'(queueCount), 1);
      chk("b2b_nopulse1", 32'(decodePulse), 0);
      fetchInstr = 32'h00100113; fetchPc = 32'h1004;
      step();
      chk("b2b_pulse_a", 32'(decodePulse), 1);
      chk("b2b_avail_a", 32'(decodeAvailable), 1);
      chk("b2b_instr_a", decodeInstr, 32'h00500093);
      chk("b2b_pc_a", decodePc, 32'h1000);
      fetchInstr = 32'h002081B3; fetchPc = 32'h1008;
      step();
      chk("b2b_low_a", 32'(decodePulse), 0);
      chk("b2b_availlow_a", 32'(decodeAvailable), 0);
      fetchValid = 1'b0;
      step();
      chk("b2b_pulse_b", 32'(decodePulse), 1);
      chk("b2b_instr_b", decodeInstr, 32'h00100113);
      step();
      chk("b2b_low_b", 32'(decodePulse), 0);
      step();
      chk("b2b_pulse_c", 32'(decodePulse), 1);
      chk("b2b_instr_c", decodeInstr, 32'h002081B3);
      chk("b2b_pc_c", decodePc, 32'h1008);
      step();
      chk("b2b_low_c", 32'(decodePulse), 0);
      chk("b2b_empty", 32'(queueCount), 0);
      chk("b2b_nostall", 32'(stall), 0);

      // Full FIFO with ROB blocked
      robNotFull = 1'b0; fetchValid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         fetchInstr = 32'h100 + 32'(i); fetchPc = 32'h2000 + 32'(4*i);
         step();
      end
      chk("full_cnt", 32'(queueCount), 4);
      chk("full_ready", 32'(fetchReady), 0);
      chk("full_stall", 32'(stall), 1);
      chk("full_nopulse", 32'(decodePulse), 0);
      fetchValid = 1'b0; robNotFull = 1'b1;
      step();
      chk("full_pulse0", 32'(decodePulse), 1);
      chk("full_instr0", decodeInstr, 32'h100);
      chk("full_cnt3", 32'(queueCount), 3);
      chk("full_ready_back", 32'(fetchReady), 1);
      chk("full_stall_clr", 32'(stall), 0);
      for (int k = 1; k < 4; k++) begin
         step();
         chk("full_drain_low", 32'(decodePulse), 0);
         step();
         chk("full_drain_pulse", 32'(decodePulse), 1);
         chk("full_drain_instr", decodeInstr, 32'h100 + 32'(k));
      end
      step();
      chk("full_drained", 32'(queueCount), 0);

      // Wrap-around: 10 instructions against a cycle-level reference
      mCnt = 0; mPulse = 0; nPushed = 0; nPulses = 0;
      for (int c = 0; c < 40; c++) begin
         fetchValid = (nPushed < 10);
         fetchInstr = 32'hA000_0000 + 32'(nPushed);
         fetchPc    = 32'h3000 + 32'(4*nPushed);
         mPush  = fetchValid && (mCnt < 4);
         mIssue = !mPulse && (mCnt > 0);
         chk("wrap_ready", 32'(fetchReady), 32'(mCnt < 4));
         expInstr = '0;
         if (mIssue) expInstr = expQ.pop_front();
         if (mPush) begin
            expQ.push_back(fetchInstr);
            nPushed++;
         end
         step();
         chk("wrap_pulse", 32'(decodePulse), 32'(mIssue));
         if (mIssue) begin
            chk("wrap_instr", decodeInstr, expInstr);
            nPulses++;
         end
         mCnt   = mCnt + int'(mPush) - int'(mIssue);
         mPulse = mIssue;
         chk("wrap_cnt", 32'(queueCount), 32'(mCnt));
      end
      fetchValid = 1'b0;
      chk("wrap_total", 32'(nPulses), 10);

      // Flush while in PULSE with 2 entries queued
      robNotFull = 1'b0; fetchValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fetchInstr = 32'hB0 + 32'(i); fetchPc = 32'h4000 + 32'(4*i);
         step();
      end
      fetchValid = 1'b0; robNotFull = 1'b1;
      step();
      chk("fl_pulse", 32'(decodePulse), 1);
      chk("fl_cnt2", 32'(queueCount), 2);
      flush = 1'b1; flushPc = 32'h100; fetchValid = 1'b1; fetchInstr = 32'hDEAD;
      step();
      chk("fl_pulse_end", 32'(decodePulse), 0);
      chk("fl_cnt0", 32'(queueCount), 0);
      chk("fl_redir", 32'(fetchRedirect), 1);
      chk("fl_redir_pc", fetchRedirectPc, 32'h100);
      chk("fl_ready_blk", 32'(fetchReady), 0);
      flush = 1'b0;
      step();
      chk("fl_redir_off", 32'(fetchRedirect), 0);
      chk("fl_push_blk", 32'(queueCount), 0);
      chk("fl_ready_back", 32'(fetchReady), 1);
      fetchValid = 1'b0;
      step();
      chk("fl_nopulse1", 32'(decodePulse), 0);
      step();
      chk("fl_nopulse2", 32'(decodePulse), 0);
      chk("fl_pc_hold", fetchRedirectPc, 32'h100);
      fetchValid = 1'b1; fetchInstr = 32'hC0FFEE; fetchPc = 32'h100;
      step();
      fetchValid = 1'b0;
      chk("fl_new_cnt", 32'(queueCount), 1);
      step();
      chk("fl_new_pulse", 32'(decodePulse), 1);
      chk("fl_new_instr", decodeInstr, 32'hC0FFEE);
      step();

      // Flush held across FLUSH re-latches the target
      flush = 1'b1; flushPc = 32'h200;
      step();
      flushPc = 32'h300;
      step();
      chk("fl2_redir", 32'(fetchRedirect), 1);
      chk("fl2_pc", fetchRedirectPc, 32'h300);
      flush = 1'b0;
      step();
      chk("fl2_redir_off", 32'(fetchRedirect), 0);
      step();

      // Resource drop
      rsNotFull = 1'b0; fetchValid = 1'b1; fetchInstr = 32'hE1; fetchPc = 32'h5000;
      step();
      fetchValid = 1'b0;
      step();
      chk("rs_nopulse", 32'(decodePulse), 0);
      chk("rs_stall", 32'(stall), 1);
      rsNotFull = 1'b1;
      step();
      chk("rs_pulse", 32'(decodePulse), 1);
      chk("rs_stall_clr", 32'(stall), 0);
      chk("rs_instr", decodeInstr, 32'hE1);
      step();

      // Reset during PULSE
      robNotFull = 1'b0; fetchValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fetchInstr = 32'hF0 + 32'(i); fetchPc = 32'h6000 + 32'(4*i);
         step();
      end
      fetchValid = 1'b0; robNotFull = 1'b1;
      step();
      chk("rp_pulse", 32'(decodePulse), 1);
      chk("rp_cnt2", 32'(queueCount), 2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rp_pulse0", 32'(decodePulse), 0);
      chk("rp_avail0", 32'(decodeAvailable), 0);
      chk("rp_cnt0", 32'(queueCount), 0);
      chk("rp_ready", 32'(fetchReady), 1);
      chk("rp_instr0", decodeInstr, 0);
      chk("rp_pc0", decodePc, 0);
      chk("rp_redir_pc0", fetchRedirectPc, 0);
      chk("rp_stall0", 32'(stall), 0);
      step();
      chk("rp_idle", 32'(decodePulse), 0);

      $display("%0d/%0d checks passed", nPass, nTotal);
      $finish;
   end

endmodule
